// File: rtl/multiword_add_seq_if.sv
// Bundles the request, result and adder-drive signals of multiword_add_seq.
// The slave modport is the sequencer's view; the master modport is the environment's view.
interface multiword_add_seq_if #(
  parameter int NUM_WORDS = 4,
  parameter int WORD_W    = 32
);
  localparam int W = NUM_WORDS * WORD_W;

  logic              in_valid;
  logic              in_ready;
  logic [W-1:0]      in_a;
  logic [W-1:0]      in_b;
  logic              in_sub;

  logic [WORD_W-1:0] add_a;
  logic [WORD_W-1:0] add_b;
  logic              add_cin;
  logic [WORD_W-1:0] add_s;
  logic              add_cout;
  logic              add_ovf;

  logic              out_valid;
  logic              out_ready;
  logic [W-1:0]      out_sum;
  logic              out_cout;
  logic              out_ovf;
  logic              out_zero;

  modport slave (
    input  in_valid, in_a, in_b, in_sub, add_s, add_cout, add_ovf, out_ready,
    output in_ready, add_a, add_b, add_cin, out_valid, out_sum, out_cout, out_ovf, out_zero
  );

  modport master (
    output in_valid, in_a, in_b, in_sub, add_s, add_cout, add_ovf, out_ready,
    input  in_ready, add_a, add_b, add_cin, out_valid, out_sum, out_cout, out_ovf, out_zero
  );
endinterface

// File: rtl/multiword_add_seq.sv
// Wide add/subtract built by walking one WORD_W slice per cycle through an external
// combinational adder, LSW first, with the carry chained through a register.
//
// state | meaning
// IDLE  | ready for a new operation, adder inputs held at zero
// RUN   | slice idx_q is on the adder; result slice and carry captured each edge
// DONE  | result valid, held until out_ready
module multiword_add_seq #(
  parameter int NUM_WORDS = 4,
  parameter int WORD_W    = 32
) (
  input logic                clk,
  input logic                rst_n,
  multiword_add_seq_if.slave bus
);
  localparam int W     = NUM_WORDS * WORD_W;
  localparam int IDX_W = $clog2(NUM_WORDS);
  localparam int OFF_W = $clog2(W);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t            state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic              carry_q, carry_d;
  logic              sub_q, sub_d;
  logic              ovf_q, ovf_d;
  logic [W-1:0]      a_q, a_d;
  logic [W-1:0]      b_q, b_d;
  logic [W-1:0]      sum_q, sum_d;
  logic [OFF_W-1:0]  off;
  logic              last_word;

  assign off       = OFF_W'(idx_q) * OFF_W'(WORD_W);
  assign last_word = (idx_q == IDX_W'(NUM_WORDS - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      carry_q <= 1'b0;
      sub_q   <= 1'b0;
      ovf_q   <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      sub_q   <= sub_d;
      ovf_q   <= ovf_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    carry_d     = carry_q;
    sub_d       = sub_q;
    ovf_d       = ovf_q;
    a_d         = a_q;
    b_d         = b_q;
    sum_d       = sum_q;
    bus.add_a   = '0;
    bus.add_b   = '0;
    bus.add_cin = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          a_d     = bus.in_a;
          b_d     = bus.in_b;
          sub_d   = bus.in_sub;
          idx_d   = '0;
          // subtract's +1 enters as the carry into the least significant slice
          carry_d = bus.in_sub;
          sum_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        bus.add_a          = a_q[off +: WORD_W];
        bus.add_b          = b_q[off +: WORD_W] ^ {WORD_W{sub_q}};
        bus.add_cin        = carry_q;
        sum_d[off +: WORD_W] = bus.add_s;
        carry_d            = bus.add_cout;
        if (last_word) begin
          ovf_d   = bus.add_ovf;
          state_d = DONE;
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end
      DONE: begin
        if (bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.out_sum   = sum_q;
  assign bus.out_cout  = carry_q;
  assign bus.out_ovf   = ovf_q;
  assign bus.out_zero  = (sum_q == '0);
endmodule
